// File: rtl/multi_cycle_control_sequencer.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_sequencer
//
// Sits beside a single-cycle datapath and stretches the few instructions
// that cannot finish in one cycle:
//   * PUSHM / POPM walk a register bitmap one register per cycle.
//   * OUTPUT / PAUSE / INPUT wait for an operator button. A release phase
//     follows, so that one press completes exactly one instruction.
//   * HALT parks the sequencer until reset.
// All other instructions complete in the same cycle they are presented.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low reset
//   instr_valid           id / reg_list are valid this cycle (ignored while busy)
//   id                    decoded instruction ID
//   reg_list              register bitmap for PUSHM / POPM
//   confirmation          I/O confirm button (OUTPUT, INPUT)
//   continue_button       PAUSE release button
//   enable                instruction completes this cycle; PC/regfile commit
//   busy                  sequencer is not idle
//   controlMAH            memory address handler select
//   controlRB             register bank write select
//   allow_write_on_memory memory write strobe
//   is_input / is_output  I/O device activity
//   reg_index             register addressed by the current PUSHM/POPM beat
//   io_timeout            sticky flag: an I/O wait was aborted by timeout
// -----------------------------------------------------------------------------
module multi_cycle_control_sequencer #(
    parameter int ID_WIDTH      = 7,
    parameter int LIST_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int TIMEOUT_LIMIT = 0,
    localparam int IDX_W        = (LIST_WIDTH > 1) ? $clog2(LIST_WIDTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [ID_WIDTH-1:0]   id,
    input  logic [LIST_WIDTH-1:0] reg_list,
    input  logic                  confirmation,
    input  logic                  continue_button,
    output logic                  enable,
    output logic                  busy,
    output logic [2:0]            controlMAH,
    output logic [2:0]            controlRB,
    output logic                  allow_write_on_memory,
    output logic                  is_input,
    output logic                  is_output,
    output logic [IDX_W-1:0]      reg_index,
    output logic                  io_timeout
);

    localparam logic [ID_WIDTH-1:0] ID_OUTPUT = ID_WIDTH'(69);
    localparam logic [ID_WIDTH-1:0] ID_PAUSE  = ID_WIDTH'(70);
    localparam logic [ID_WIDTH-1:0] ID_INPUT  = ID_WIDTH'(71);
    localparam logic [ID_WIDTH-1:0] ID_HALT   = ID_WIDTH'(75);
    localparam logic [ID_WIDTH-1:0] ID_PUSHM  = ID_WIDTH'(78);
    localparam logic [ID_WIDTH-1:0] ID_POPM   = ID_WIDTH'(79);

    // Counter value seen on the last permitted wait cycle.
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST =
        TIMEOUT_WIDTH'((TIMEOUT_LIMIT > 0) ? TIMEOUT_LIMIT - 1 : 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX = {TIMEOUT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MULTI      = 3'd1,
        ST_IO_WAIT    = 3'd2,
        ST_IO_RELEASE = 3'd3,
        ST_HALTED     = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [LIST_WIDTH-1:0]    list_q, list_d;
    logic                     pop_q, pop_d;
    logic [ID_WIDTH-1:0]      io_id_q, io_id_d;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                     timeout_q, timeout_d;

    logic [IDX_W-1:0]         hi_idx;
    logic [IDX_W-1:0]         lo_idx;
    logic [IDX_W-1:0]         beat_idx;
    logic                     last_beat;
    logic                     handshake;
    logic                     timeout_fire;

    // Highest and lowest set bit of the remaining list. Each loop keeps its
    // last hit, so the scan direction decides which end wins.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < LIST_WIDTH; i++) begin
            if (list_q[i]) hi_idx = IDX_W'(i);
        end
        for (int i = LIST_WIDTH - 1; i >= 0; i--) begin
            if (list_q[i]) lo_idx = IDX_W'(i);
        end
    end

    // PUSHM stores from the top down; POPM restores from the bottom up.
    assign beat_idx  = pop_q ? lo_idx : hi_idx;
    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign last_beat = ((list_q & (list_q - LIST_WIDTH'(1))) == '0);
    // PAUSE is released by its own button; OUTPUT/INPUT use confirmation.
    assign handshake = (io_id_q == ID_PAUSE) ? continue_button : confirmation;

    always_comb begin
        state_d               = state_q;
        list_d                = list_q;
        pop_d                 = pop_q;
        io_id_d               = io_id_q;
        wait_cnt_d            = wait_cnt_q;
        timeout_d             = timeout_q;
        timeout_fire          = 1'b0;
        enable                = 1'b0;
        busy                  = 1'b0;
        controlMAH            = 3'd0;
        controlRB             = 3'd0;
        allow_write_on_memory = 1'b0;
        is_input              = 1'b0;
        is_output             = 1'b0;
        reg_index             = '0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (id == ID_PUSHM || id == ID_POPM) begin
                        if (reg_list != '0) begin
                            list_d  = reg_list;
                            pop_d   = (id == ID_POPM);
                            state_d = ST_MULTI;
                        end else begin
                            // Empty list degenerates into a NOP.
                            enable = 1'b1;
                        end
                    end else if (id == ID_OUTPUT || id == ID_PAUSE || id == ID_INPUT) begin
                        io_id_d    = id;
                        wait_cnt_d = '0;
                        state_d    = ST_IO_WAIT;
                    end else if (id == ID_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        enable = 1'b1;
                    end
                end
            end

            ST_MULTI: begin
                busy      = 1'b1;
                reg_index = beat_idx;
                if (pop_q) begin
                    controlMAH = 3'd2;
                    controlRB  = 3'd3;
                end else begin
                    controlMAH            = 3'd1;
                    allow_write_on_memory = 1'b1;
                end
                list_d = list_q & ~(LIST_WIDTH'(1) << beat_idx);
                if (last_beat) begin
                    enable  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_IO_WAIT: begin
                busy      = 1'b1;
                is_output = (io_id_q == ID_OUTPUT) || (io_id_q == ID_PAUSE);
                is_input  = (io_id_q == ID_PAUSE) || (io_id_q == ID_INPUT);
                controlRB = (io_id_q == ID_INPUT) ? 3'd3 : 3'd0;
                if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
                end
                // A press on the deadline cycle still counts as a completion.
                if (handshake) begin
                    enable  = 1'b1;
                    state_d = ST_IO_RELEASE;
                end else if (TIMEOUT_LIMIT != 0 && wait_cnt_q == WAIT_LAST) begin
                    enable       = 1'b1;
                    timeout_fire = 1'b1;
                    timeout_d    = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_IO_RELEASE: begin
                busy = 1'b1;
                if (!handshake) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HALTED: begin
                busy = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        io_timeout = timeout_q | timeout_fire;

        // Outputs must drop the moment reset is asserted, including the
        // combinational same-cycle enable that IDLE can produce.
        if (!reset) begin
            enable                = 1'b0;
            busy                  = 1'b0;
            controlMAH            = 3'd0;
            controlRB             = 3'd0;
            allow_write_on_memory = 1'b0;
            is_input              = 1'b0;
            is_output             = 1'b0;
            reg_index             = '0;
            io_timeout            = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            list_q     <= '0;
            pop_q      <= 1'b0;
            io_id_q    <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            pop_q      <= pop_d;
            io_id_q    <= io_id_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for multi_cycle_control_sequencer (TIMEOUT_LIMIT = 4).
// Each instruction is expanded by the bench into its expected per-cycle
// output sequence straight from the instruction rules: bit lists for
// PUSHM/POPM, a press schedule for I/O, a sticky timeout flag.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control_sequencer;

    localparam int TO_LIMIT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic [6:0] id = '0;
    logic [7:0] reg_list = '0;
    logic       confirmation = 1'b0;
    logic       continue_button = 1'b0;

    logic       enable;
    logic       busy;
    logic [2:0] controlMAH;
    logic [2:0] controlRB;
    logic       allow_write_on_memory;
    logic       is_input;
    logic       is_output;
    logic [2:0] reg_index;
    logic       io_timeout;

    multi_cycle_control_sequencer #(
        .ID_WIDTH      (7),
        .LIST_WIDTH    (8),
        .TIMEOUT_WIDTH (16),
        .TIMEOUT_LIMIT (TO_LIMIT)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .instr_valid           (instr_valid),
        .id                    (id),
        .reg_list              (reg_list),
        .confirmation          (confirmation),
        .continue_button       (continue_button),
        .enable                (enable),
        .busy                  (busy),
        .controlMAH            (controlMAH),
        .controlRB             (controlRB),
        .allow_write_on_memory (allow_write_on_memory),
        .is_input              (is_input),
        .is_output             (is_output),
        .reg_index             (reg_index),
        .io_timeout            (io_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_to   = 1'b0;   // sticky timeout flag as the bench expects it

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h (en,busy,mah,rb,wr,in,out,idx,to)",
                      tag, got, exp);
    endtask

    function automatic logic [31:0] obs();
        return {17'b0, enable, busy, controlMAH, controlRB, allow_write_on_memory,
                is_input, is_output, reg_index, io_timeout};
    endfunction

    function automatic logic [31:0] expv(bit en, bit bz, int mah, int rb, bit wr,
                                         bit in_act, bit out_act, int idx, bit to);
        return {17'b0, en, bz, 3'(mah), 3'(rb), wr, in_act, out_act, 3'(idx), to};
    endfunction

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic cyc(input string tag, input logic [31:0] exp);
        @(negedge clock);
        check(tag, obs(), exp);
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        instr_valid = 1'b0;
        id          = '0;
        reg_list    = '0;
    endtask

    // Random instruction inputs that a busy sequencer must ignore.
    task automatic garbage();
        instr_valid = 1'($urandom_range(0, 1));
        id          = 7'($urandom_range(0, 127));
        reg_list    = 8'($urandom);
    endtask

    task automatic idle_check(input string tag);
        quiet();
        confirmation    = 1'b0;
        continue_button = 1'b0;
        cyc(tag, expv(0, 0, 0, 0, 0, 0, 0, 0, exp_to));
    endtask

    task automatic do_reset();
        quiet();
        garbage();
        reset  = 1'b0;
        exp_to = 1'b0;
        cyc("reset_low", expv(0, 0, 0, 0, 0, 0, 0, 0, 0));
        quiet();
        reset = 1'b1;
        $display("txn reset");
    endtask

    task automatic do_simple(input logic [6:0] op);
        instr_valid = 1'b1;
        id          = op;
        reg_list    = 8'($urandom);
        cyc("simple", expv(1, 0, 0, 0, 0, 0, 0, 0, exp_to));
        quiet();
        $display("txn simple id=%0d", op);
    endtask

    // abort_beat: 0 = run to completion, k = pull reset low during beat k.
    task automatic do_multi(input bit pop, input logic [7:0] lst, input int abort_beat);
        int q[$];
        int last;
        if (pop) begin
            for (int i = 0; i < 8; i++) if (lst[i]) q.push_back(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (lst[i]) q.push_back(i);
        end
        instr_valid = 1'b1;
        id          = pop ? 7'd79 : 7'd78;
        reg_list    = lst;
        if (q.size() == 0) begin
            cyc("multi_nop", expv(1, 0, 0, 0, 0, 0, 0, 0, exp_to));
            quiet();
            $display("txn %s list=%02h nop", pop ? "popm" : "pushm", lst);
            return;
        end
        cyc("multi_issue", expv(0, 0, 0, 0, 0, 0, 0, 0, exp_to));
        last = q.size() - 1;
        for (int k = 0; k <= last; k++) begin
            garbage();
            if (abort_beat == k + 1) begin
                reset  = 1'b0;
                exp_to = 1'b0;
                cyc("multi_reset", expv(0, 0, 0, 0, 0, 0, 0, 0, 0));
                cyc("multi_reset_hold", expv(0, 0, 0, 0, 0, 0, 0, 0, 0));
                reset = 1'b1;
                idle_check("multi_after_reset");
                $display("txn %s list=%02h aborted at beat %0d", pop ? "popm" : "pushm",
                         lst, abort_beat);
                return;
            end
            cyc("multi_beat", expv(k == last, 1, pop ? 2 : 1, pop ? 3 : 0, !pop, 0, 0,
                                   q[k], exp_to));
        end
        idle_check("multi_done");
        $display("txn %s list=%02h beats=%0d", pop ? "popm" : "pushm", lst, q.size());
    endtask

    // press_at: wait cycle (1-based) on which the handshake rises; hold: cycles high.
    task automatic do_io(input logic [6:0] op, input int press_at, input int hold);
        bit pause = (op == 7'd70);
        bit out_e = (op != 7'd71);
        bit in_e  = (op != 7'd69);
        int rb_e  = (op == 7'd71) ? 3 : 0;
        bit hs;
        bit done  = 1'b0;
        bit timed = 1'b0;
        int w     = 1;
        instr_valid = 1'b1;
        id          = op;
        cyc("io_issue", expv(0, 0, 0, 0, 0, 0, 0, 0, exp_to));
        while (!done) begin
            garbage();
            hs = (w >= press_at) && (w < press_at + hold);
            if (pause) begin
                continue_button = hs;
                confirmation    = 1'($urandom_range(0, 1));
            end else begin
                confirmation    = hs;
                continue_button = 1'($urandom_range(0, 1));
            end
            if (hs) begin
                cyc("io_wait_done", expv(1, 1, 0, rb_e, 0, in_e, out_e, 0, exp_to));
                done = 1'b1;
            end else if (w == TO_LIMIT) begin
                exp_to = 1'b1;
                cyc("io_timeout", expv(1, 1, 0, rb_e, 0, in_e, out_e, 0, 1));
                done  = 1'b1;
                timed = 1'b1;
            end else begin
                cyc("io_wait", expv(0, 1, 0, rb_e, 0, in_e, out_e, 0, exp_to));
            end
            w++;
        end
        if (!timed) begin
            done = 1'b0;
            while (!done) begin
                garbage();
                hs = (w >= press_at) && (w < press_at + hold);
                if (pause) begin
                    continue_button = hs;
                    confirmation    = 1'($urandom_range(0, 1));
                end else begin
                    confirmation    = hs;
                    continue_button = 1'($urandom_range(0, 1));
                end
                cyc("io_release", expv(0, 1, 0, 0, 0, 0, 0, 0, exp_to));
                if (!hs) done = 1'b1;
                w++;
            end
        end
        idle_check("io_done");
        $display("txn io id=%0d press_at=%0d hold=%0d timeout=%0d", op, press_at, hold, timed);
    endtask

    task automatic do_halt();
        instr_valid = 1'b1;
        id          = 7'd75;
        cyc("halt_issue", expv(0, 0, 0, 0, 0, 0, 0, 0, exp_to));
        for (int k = 0; k < 3; k++) begin
            instr_valid = 1'b1;
            id          = 7'd4;
            cyc("halted", expv(0, 1, 0, 0, 0, 0, 0, 0, exp_to));
        end
        $display("txn halt");
        do_reset();
        idle_check("halt_after_reset");
    endtask

    function automatic logic [6:0] plain_id();
        logic [6:0] v;
        do v = 7'($urandom_range(0, 127));
        while (v inside {7'd69, 7'd70, 7'd71, 7'd75, 7'd78, 7'd79});
        return v;
    endfunction

    initial begin
        quiet();
        reset = 1'b0;
        @(posedge clock);
        #1;
        instr_valid = 1'b1;
        id          = 7'd4;
        cyc("reset_state", expv(0, 0, 0, 0, 0, 0, 0, 0, 0));
        quiet();
        reset = 1'b1;

        // First instruction straight after release.
        do_multi(1'b0, 8'b1001_0010, 0);
        do_multi(1'b1, 8'b0000_0101, 0);
        do_multi(1'b1, 8'b0000_0000, 0);
        do_multi(1'b0, 8'b1111_1111, 0);
        do_simple(7'd4);
        do_io(7'd71, 3, 5);
        do_io(7'd70, 1, 2);
        do_io(7'd69, 4, 1);     // press on the deadline cycle beats the timeout
        do_io(7'd69, 20, 1);    // never pressed: times out on wait cycle 4
        do_simple(7'd12);       // timeout flag stays set
        do_multi(1'b0, 8'b1001_0010, 2);
        do_simple(7'd33);
        do_halt();

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0, 1: do_simple(plain_id());
                2, 3: do_multi(1'b0, 8'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0);
                4, 5: do_multi(1'b1, 8'($urandom), 0);
                6, 7: begin
                    case ($urandom_range(0, 2))
                        0:       do_io(7'd69, $urandom_range(1, 6), $urandom_range(1, 4));
                        1:       do_io(7'd70, $urandom_range(1, 6), $urandom_range(1, 4));
                        default: do_io(7'd71, $urandom_range(1, 6), $urandom_range(1, 4));
                    endcase
                end
                8: begin
                    do_reset();
                    do_simple(plain_id());
                end
                default: do_halt();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multi_cycle_control_sequencer.md
MULTI_CYCLE_CONTROL_SEQUENCER -- requirements
Module: multi_cycle_control_sequencer

Interface
REQ-001 SHALL provide parameter ID_WIDTH, default 7, instruction ID width.
REQ-002 SHALL provide parameter LIST_WIDTH, default 8, register-list width; index width IDX_W = clog2(LIST_WIDTH).
REQ-003 SHALL provide parameter TIMEOUT_WIDTH, default 16, I/O wait counter width.
REQ-004 SHALL provide parameter TIMEOUT_LIMIT, default 0, I/O wait cycles before abort; 0 disables timeout.
REQ-005 Ports SHALL be:
  clock  in  1  single clock, all state on rising edge.
  reset  in  1  asynchronous, active-low reset.
  instr_valid  in  1  id/reg_list valid this cycle.
  id  in  ID_WIDTH  decoded instruction ID.
  reg_list  in  LIST_WIDTH  register bitmap for PUSHM/POPM.
  confirmation  in  1  I/O confirm button.
  continue_button  in  1  PAUSE release button.
  enable  out  1  instruction completes this cycle; PC/regfile may commit.
  busy  out  1  sequencer not in IDLE.
  controlMAH  out  3  memory address handler select.
  controlRB  out  3  register bank write select.
  allow_write_on_memory  out  1  memory write strobe.
  is_input  out  1  input device active.
  is_output  out  1  output device active.
  reg_index  out  IDX_W  register addressed by current PUSHM/POPM beat.
  io_timeout  out  1  sticky: an I/O wait was aborted by timeout.

Function
REQ-006 States SHALL be IDLE, MULTI, IO_WAIT, IO_RELEASE, HALTED.
REQ-007 IDLE, instr_valid=0: enable=0, all control outputs 0, no transition.
REQ-008 IDLE, instr_valid=1, id not in {69,70,71,75,78,79}: enable=1 same cycle (combinational), stay IDLE.
REQ-009 IDLE, id=78 (PUSHM) or 79 (POPM), reg_list!=0: latch reg_list and opcode, enable=0, go MULTI next cycle.
REQ-010 IDLE, id=78/79, reg_list=0: behave as NOP, enable=1, stay IDLE.
REQ-011 MULTI, PUSHM: each cycle reg_index = highest set bit of latched list, controlMAH=1, allow_write_on_memory=1, controlRB=0; that bit clears at clock edge.
REQ-012 MULTI, POPM: each cycle reg_index = lowest set bit, controlMAH=2, controlRB=3, allow_write_on_memory=0; bit clears at clock edge.
REQ-013 MULTI SHALL assert enable=1 in the beat whose list has exactly one bit set, then go IDLE; N set bits -> N MULTI cycles, total latency N+1 cycles.
REQ-014 IDLE, id in {69 OUTPUT, 70 PAUSE, 71 INPUT}: latch id, clear wait counter, go IO_WAIT, enable=0.
REQ-015 IO_WAIT SHALL drive is_output=1 for 69/70 and is_input=1 for 70/71; controlRB=3 for 71, else 0; wait counter increments each cycle, saturating.
REQ-016 IO_WAIT SHALL complete when its handshake is high (confirmation for 69/71, continue_button for 70): enable=1 that cycle, go IO_RELEASE.
REQ-017 IO_RELEASE: enable=0, is_input/is_output=0; go IDLE when handshake low, so one press completes exactly one instruction.
REQ-018 IO_WAIT, TIMEOUT_LIMIT!=0, counter = TIMEOUT_LIMIT-1 without handshake: set io_timeout, enable=1, go IDLE; handshake high in the same cycle takes priority (REQ-016, no timeout).
REQ-019 IDLE, id=75 (HALT): go HALTED; HALTED holds enable=0, busy=1, outputs 0, until reset.
REQ-020 busy SHALL be 1 in every state except IDLE; instr_valid SHALL be ignored while busy.
REQ-021 reg_index SHALL be 0 outside MULTI.

Reset
REQ-022 reset low SHALL immediately force IDLE, clear latched list/id, wait counter and io_timeout; all outputs 0.
REQ-023 Reset mid-MULTI or mid-IO_WAIT SHALL abandon the operation with no further enable or memory-write pulse.
REQ-024 First instruction after reset release SHALL be accepted on the first rising edge with reset high.

Verification
REQ-025 PUSHM reg_list=8'b1001_0010 -> 3 beats reg_index 7,4,1, allow_write_on_memory=1 each, enable=1 only on beat 3, busy for 3 cycles.
REQ-026 POPM reg_list=8'b0000_0101 -> reg_index 0 then 2, controlRB=3, enable on second beat; reg_list=0 -> enable=1 same cycle, busy stays 0.
REQ-027 INPUT, confirmation held high 5 cycles from cycle 3 -> enable exactly one cycle (cycle 3), is_input high cycles 1-3, IDLE after confirmation falls.
REQ-028 TIMEOUT_LIMIT=4, OUTPUT, no confirmation -> enable=1 and io_timeout=1 on 4th IO_WAIT cycle, io_timeout stays 1 until reset.
REQ-029 HALT then instr_valid with id=4 -> enable stays 0; reset low mid-PUSHM beat 2 -> outputs 0 immediately, IDLE after release.
